reg_file_32x32: RTL and testbench

- 32-entry x 32-bit register file for the single-cycle/multi-cycle CPU datapath.
- Sits directly downstream of the 5-to-32 write-address decoder. Internally, a 5-bit write address plus write enable is expanded to 32 one-hot row enables, and each row register captures write data when its enable is high.
- Two asynchronous read ports feed the ALU operand muxes.
- Register 0 is hardwired to zero.

---
 rtl/reg_file_32x32.sv | 70 +++++++
 tb/tb_reg_file_32x32.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/reg_file_32x32.sv
// 32-entry register file: decoded one-hot row writes, two combinational read ports,
// register 0 hardwired to zero, optional write-through bypass on reads.
module reg_file_32x32 #(
  parameter int unsigned WIDTH  = 32,
  parameter bit          BYPASS = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             we_i,
  input  logic [4:0]       waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [4:0]       raddr1_i,
  input  logic [4:0]       raddr2_i,
  output logic [WIDTH-1:0] rdata1_o,
  output logic [WIDTH-1:0] rdata2_o,
  output logic [31:0]      wr_onehot_o
);

  logic [31:0]      row_en;
  logic [WIDTH-1:0] regs_q  [1:31];
  logic [WIDTH-1:0] regs_d  [1:31];
  logic [WIDTH-1:0] rd_view [32];

  // Row 0 never gets an enable, so address 0 can neither be written nor bypassed.
  always_comb begin
    row_en = '0;
    if (we_i) begin
      row_en[waddr_i] = 1'b1;
    end
    row_en[0] = 1'b0;
  end

  assign wr_onehot_o = row_en;

  always_comb begin
    for (int i = 1; i < 32; i++) begin
      regs_d[i] = row_en[i] ? wdata_i : regs_q[i];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 1; i < 32; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int i = 1; i < 32; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  always_comb begin
    rd_view[0] = '0;
    for (int i = 1; i < 32; i++) begin
      rd_view[i] = (BYPASS && row_en[i]) ? wdata_i : regs_q[i];
    end
  end

  assign rdata1_o = rd_view[raddr1_i];
  assign rdata2_o = rd_view[raddr2_i];

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      assert ($onehot0(row_en))
      else $error("row write enables not one-hot: %b", row_en);
    end
  end

endmodule

// File: tb/tb_reg_file_32x32.sv
// Drives a write-through and a plain register file in lockstep and checks both
// against an array model of the register contents.
module tb_reg_file_32x32;

  logic        clk = 1'b0;
  logic        rst, we;
  logic [4:0]  waddr, raddr1, raddr2;
  logic [31:0] wdata;
  logic [31:0] r1_nb, r2_nb, oh_nb, r1_bp, r2_bp, oh_bp;

  int vectors    = 0;
  int miscompares = 0;

  logic [31:0] model [32];

  always #5 clk = ~clk;

  reg_file_32x32 #(.WIDTH(32), .BYPASS(1'b0)) u_dut_nb (
    .clk_i(clk), .rst_i(rst), .we_i(we), .waddr_i(waddr), .wdata_i(wdata),
    .raddr1_i(raddr1), .raddr2_i(raddr2),
    .rdata1_o(r1_nb), .rdata2_o(r2_nb), .wr_onehot_o(oh_nb)
  );

  reg_file_32x32 #(.WIDTH(32), .BYPASS(1'b1)) u_dut_bp (
    .clk_i(clk), .rst_i(rst), .we_i(we), .waddr_i(waddr), .wdata_i(wdata),
    .raddr1_i(raddr1), .raddr2_i(raddr2),
    .rdata1_o(r1_bp), .rdata2_o(r2_bp), .wr_onehot_o(oh_bp)
  );

  typedef struct {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [31:0] exp1;
    logic [31:0] exp2;
    logic [31:0] exp_oh;
  } vec_t;

  vec_t tbl [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_read(input logic [4:0] a, input bit byp);
    if (a == 5'd0) return 32'h0;
    if (byp && we && waddr == a) return wdata;
    return model[a];
  endfunction

  function automatic logic [31:0] ref_onehot();
    if (!we || waddr == 5'd0) return 32'h0;
    return 32'h1 << waddr;
  endfunction

  // Compare every output of both instances against the model for the current inputs.
  task automatic check_all(input string tag);
    chk({tag, " rdata1 nb"}, r1_nb, ref_read(raddr1, 1'b0));
    chk({tag, " rdata2 nb"}, r2_nb, ref_read(raddr2, 1'b0));
    chk({tag, " rdata1 bp"}, r1_bp, ref_read(raddr1, 1'b1));
    chk({tag, " rdata2 bp"}, r2_bp, ref_read(raddr2, 1'b1));
    chk({tag, " onehot nb"}, oh_nb, ref_onehot());
    chk({tag, " onehot bp"}, oh_bp, ref_onehot());
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
    end else if (we && waddr != 5'd0) begin
      model[waddr] = wdata;
    end
    #1;
  endtask

  task automatic write(input logic [4:0] a, input logic [31:0] d);
    we = 1'b1; waddr = a; wdata = d;
    tick();
    we = 1'b0;
  endtask

  initial begin
    tbl[0] = '{1'b1, 5'd3,  32'h0000_0033, 5'd3,  5'd0,  32'h0000_0033, 32'h0,         32'h0000_0008};
    tbl[1] = '{1'b1, 5'd31, 32'h0000_CAFE, 5'd31, 5'd3,  32'h0000_CAFE, 32'h0000_0033, 32'h8000_0000};
    tbl[2] = '{1'b1, 5'd0,  32'hFFFF_FFFF, 5'd0,  5'd31, 32'h0,         32'h0000_CAFE, 32'h0};
    tbl[3] = '{1'b0, 5'd3,  32'h0000_0055, 5'd3,  5'd3,  32'h0000_0033, 32'h0000_0033, 32'h0};
    tbl[4] = '{1'b1, 5'd3,  32'h0000_0044, 5'd3,  5'd31, 32'h0000_0044, 32'h0000_CAFE, 32'h0000_0008};
    tbl[5] = '{1'b1, 5'd1,  32'h0000_0001, 5'd1,  5'd2,  32'h0000_0001, 32'h0,         32'h0000_0002};

    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    rst = 1'b1; we = 1'b0; waddr = 5'd0; wdata = 32'h0; raddr1 = 5'd0; raddr2 = 5'd0;
    tick();
    rst = 1'b0;
    raddr1 = 5'd17; raddr2 = 5'd31;
    #1 check_all("post-reset");

    // Table vectors: onehot checked before the edge, reads checked after it.
    for (int v = 0; v < 6; v++) begin
      we = tbl[v].we; waddr = tbl[v].waddr; wdata = tbl[v].wdata;
      raddr1 = tbl[v].ra1; raddr2 = tbl[v].ra2;
      #1 chk($sformatf("tbl%0d onehot", v), oh_nb, tbl[v].exp_oh);
      tick();
      chk($sformatf("tbl%0d rdata1", v), r1_nb, tbl[v].exp1);
      chk($sformatf("tbl%0d rdata2", v), r2_nb, tbl[v].exp2);
    end
    we = 1'b0;

    // Reset discards contents, and beats a simultaneous write.
    write(5'd5, 32'hDEAD_BEEF);
    rst = 1'b1; tick(); rst = 1'b0;
    raddr1 = 5'd5; raddr2 = 5'd31;
    #1 chk("reset R5", r1_nb, 32'h0);
    chk("reset R31", r2_nb, 32'h0);
    rst = 1'b1; we = 1'b1; waddr = 5'd3; wdata = 32'h1234_5678;
    tick();
    rst = 1'b0; we = 1'b0; raddr1 = 5'd3;
    #1 chk("rst beats write R3", r1_nb, 32'h0);
    write(5'd6, 32'h0000_0066);
    raddr1 = 5'd6;
    #1 chk("first write after rst", r1_nb, 32'h0000_0066);

    // Full sweep.
    for (int i = 1; i < 32; i++) begin
      we = 1'b1; waddr = 5'(i); wdata = 32'hA500_0000 | 32'(i);
      #1 chk($sformatf("sweep onehot %0d", i), oh_nb, 32'h1 << i);
      tick();
    end
    we = 1'b0;
    for (int i = 1; i < 32; i++) begin
      raddr1 = 5'(i); raddr2 = 5'(32 - i);
      #1 chk($sformatf("sweep rd1 %0d", i), r1_nb, 32'hA500_0000 | 32'(i));
      chk($sformatf("sweep rd2 %0d", i), r2_nb, 32'hA500_0000 | 32'(32 - i));
    end

    // Register 0 and write-enable gating.
    we = 1'b1; waddr = 5'd0; wdata = 32'hFFFF_FFFF; raddr1 = 5'd0; raddr2 = 5'd0;
    #1 chk("r0 onehot", oh_nb, 32'h0);
    chk("r0 bypass", r1_bp, 32'h0);
    tick();
    chk("r0 after write", r1_nb, 32'h0);
    write(5'd7, 32'h1111_1111);
    we = 1'b0; waddr = 5'd7; wdata = 32'h55AA_55AA; raddr1 = 5'd7;
    #1 chk("gated onehot", oh_nb, 32'h0);
    tick();
    chk("gated R7", r1_nb, 32'h1111_1111);
    waddr = 'x;
    tick();
    chk("x waddr R7", r1_nb, 32'h1111_1111);
    waddr = 5'd0;

    // Same-cycle read/write of R9.
    write(5'd9, 32'h1);
    we = 1'b1; waddr = 5'd9; wdata = 32'h2; raddr1 = 5'd9;
    #1 chk("raw pre nb", r1_nb, 32'h1);
    chk("raw pre bp", r1_bp, 32'h2);
    tick();
    chk("raw post nb", r1_nb, 32'h2);
    chk("raw post bp", r1_bp, 32'h2);
    we = 1'b0;

    // Back-to-back writes to R4.
    raddr2 = 5'd4;
    write(5'd4, 32'h10);
    chk("b2b N", r2_nb, 32'h10);
    write(5'd4, 32'h20);
    chk("b2b N+1", r2_nb, 32'h20);
    #1 check_all("b2b others");

    // Randomized traffic against the model, pre-edge and post-edge.
    for (int n = 0; n < 400; n++) begin
      rst    = ($urandom_range(0, 40) == 0);
      we     = ($urandom_range(0, 3) != 0);
      waddr  = 5'($urandom_range(0, 31));
      wdata  = $urandom;
      raddr1 = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom_range(0, 31));
      raddr2 = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom_range(0, 31));
      #1 check_all($sformatf("rand%0d pre", n));
      tick();
      rst = 1'b0;
      we  = 1'b0;
      #1 check_all($sformatf("rand%0d post", n));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
